// File: rtl/fu_stage_fifo_if.sv
// Handshake/bus bundle between the execute-stage FU, the staging FIFO and the
// RAM/writeback consumer of one issue way.
interface fu_stage_fifo_if #(
  parameter int DATA_W = 216,
  parameter int PID_W  = 2,
  parameter int CNT_W  = 3
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and neither side's valid/ready
  // depends combinationally on the other side's inputs.
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PID_W-1:0]  in_pid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PID_W-1:0]  out_pid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              flush_all_i;
  logic              kill_i;
  logic [PID_W-1:0]  kill_pid_i;
  logic [CNT_W-1:0]  count_o;
  logic              almost_full_o;
  logic              overflow_o;

  modport slave (
    input  in_valid_i, in_pid_i, in_data_i, out_ready_i,
    input  flush_all_i, kill_i, kill_pid_i,
    output in_ready_o, out_valid_o, out_pid_o, out_data_o,
    output count_o, almost_full_o, overflow_o
  );

  modport master (
    output in_valid_i, in_pid_i, in_data_i, out_ready_i,
    output flush_all_i, kill_i, kill_pid_i,
    input  in_ready_o, out_valid_o, out_pid_o, out_data_o,
    input  count_o, almost_full_o, overflow_o
  );
endinterface

// File: rtl/fu_stage_fifo.sv
// FU result staging FIFO with per-entry pipeline-ID tags, full flush and
// selective kill by pipeline ID; dead entries drain one per cycle.
module fu_stage_fifo #(
  parameter int DATA_W   = 216,
  parameter int DEPTH    = 4,
  parameter int PID_W    = 2,
  parameter int AFULL_TH = 3
) (
  input  logic              clk,
  input  logic              reset,
  fu_stage_fifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     r_wptr;
  logic [DEPTH-1:0]  r_alive;
  logic [PID_W-1:0]  r_pid  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_overflow;

  logic [AW-1:0]     w_ridx;
  logic [AW-1:0]     w_widx;
  logic              w_empty;
  logic              w_full;
  logic              w_head_alive;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_drain;
  logic              w_adv;
  logic              w_kill_in;
  logic [PW-1:0]     w_count;
  logic [DEPTH-1:0]  w_alive_nxt;

  assign w_ridx       = r_rptr[AW-1:0];
  assign w_widx       = r_wptr[AW-1:0];
  assign w_empty      = (r_rptr == r_wptr);
  assign w_full       = (w_ridx == w_widx) && (r_rptr[AW] != r_wptr[AW]);
  assign w_head_alive = r_alive[w_ridx];
  assign w_out_valid  = !w_empty && w_head_alive;
  assign w_push       = bus.in_valid_i && !w_full;
  assign w_pop        = w_out_valid && bus.out_ready_i;
  assign w_drain      = !w_empty && !w_head_alive;
  assign w_adv        = w_pop || w_drain;
  assign w_kill_in    = bus.kill_i && (bus.in_pid_i == bus.kill_pid_i);
  assign w_count      = r_wptr - r_rptr;

  // Kill clears matching slots; free slots may be touched too since a push
  // always rewrites the alive bit of the slot it fills.
  always_comb begin
    w_alive_nxt = r_alive;
    if (bus.kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_pid[i] == bus.kill_pid_i) w_alive_nxt[i] = 1'b0;
      end
    end
    if (w_push) w_alive_nxt[w_widx] = !w_kill_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_alive    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.in_valid_i && w_full) r_overflow <= 1'b1;
      if (bus.flush_all_i) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_alive <= '0;
      end else begin
        if (w_adv)  r_rptr <= r_rptr + PW'(1);
        if (w_push) r_wptr <= r_wptr + PW'(1);
        r_alive <= w_alive_nxt;
      end
    end
  end

  // Payload and tag storage needs no reset: alive/pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush_all_i) begin
      r_data[w_widx] <= bus.in_data_i;
      r_pid[w_widx]  <= bus.in_pid_i;
    end
  end

  assign bus.in_ready_o    = !w_full;
  assign bus.out_valid_o   = w_out_valid;
  assign bus.out_pid_o     = r_pid[w_ridx];
  assign bus.out_data_o    = r_data[w_ridx];
  assign bus.count_o       = w_count;
  assign bus.almost_full_o = (w_count >= PW'(AFULL_TH));
  assign bus.overflow_o    = r_overflow;
endmodule

// File: tb/tb_fu_stage_fifo.sv
// Bench for fu_stage_fifo: vector table, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_fu_stage_fifo;
  localparam int DW    = 216;
  localparam int DEPTH = 4;
  localparam int PIDW  = 2;
  localparam int CW    = 3;
  localparam int AFTH  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  fu_stage_fifo_if #(.DATA_W(DW), .PID_W(PIDW), .CNT_W(CW)) bus ();

  fu_stage_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PID_W(PIDW), .AFULL_TH(AFTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic            alive;
    logic [PIDW-1:0] pid;
    logic [DW-1:0]   data;
  } ent_t;

  ent_t          model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_valid;
  logic          m_ready;
  ent_t          m_ent;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Inputs change only at posedge+1, so at negedge they are the values the
  // next rising edge will sample.
  always @(negedge clk) begin
    m_ready = (model_q.size() < DEPTH);
    m_valid = (model_q.size() > 0) && model_q[0].alive;
    if (chk_en) begin
      chk("m_in_ready",  bus.in_ready_o,    m_ready);
      chk("m_out_valid", bus.out_valid_o,   m_valid);
      chk("m_count",     bus.count_o,       model_q.size());
      chk("m_afull",     bus.almost_full_o, model_q.size() >= AFTH);
      chk("m_overflow",  bus.overflow_o,    m_ovf);
      if (m_valid) begin
        chk("m_out_pid",  bus.out_pid_o,  model_q[0].pid);
        chk("m_out_data", bus.out_data_o, model_q[0].data);
      end
    end
    if (reset) begin
      model_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.in_valid_i && !m_ready) m_ovf = 1'b1;
      if (bus.flush_all_i) begin
        model_q.delete();
      end else begin
        if (model_q.size() > 0 && (!model_q[0].alive || bus.out_ready_i))
          void'(model_q.pop_front());
        if (bus.kill_i)
          for (int i = 0; i < model_q.size(); i++)
            if (model_q[i].pid == bus.kill_pid_i) model_q[i].alive = 1'b0;
        if (bus.in_valid_i && m_ready) begin
          m_ent.alive = !(bus.kill_i && bus.in_pid_i == bus.kill_pid_i);
          m_ent.pid   = bus.in_pid_i;
          m_ent.data  = bus.in_data_i;
          model_q.push_back(m_ent);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [PIDW-1:0] pid, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic kl, input logic [PIDW-1:0] kpid);
    bus.in_valid_i  = iv;
    bus.in_pid_i    = pid;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
    bus.flush_all_i = fl;
    bus.kill_i      = kl;
    bus.kill_pid_i  = kpid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, ordy, 1'b0, 1'b0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            iv;
    logic [PIDW-1:0] pid;
    logic [7:0]      d;
    logic            ordy;
    logic            kill;
    logic [PIDW-1:0] kpid;
    logic [CW-1:0]   e_cnt;
    logic            e_ov;
    logic            e_ir;
    logic            e_af;
    logic [PIDW-1:0] e_pid;
    logic [7:0]      e_d;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // fill to full with the consumer stalled, then drain in order
    vecs[0]  = '{1'b1, 2'd0, 8'hA0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA0};
    vecs[1]  = '{1'b1, 2'd1, 8'hA1, 1'b0, 1'b0, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA0};
    vecs[2]  = '{1'b1, 2'd2, 8'hA2, 1'b0, 1'b0, 2'd0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 8'hA0};
    vecs[3]  = '{1'b1, 2'd3, 8'hA3, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b1, 2'd0, 8'hA0};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA1};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 2'd2, 8'hA2};
    vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd3, 8'hA3};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    // pids {0,1,0,2}, kill pid 0, consumer sees only pid 1 and pid 2
    vecs[8]  = '{1'b1, 2'd0, 8'h10, 1'b0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h10};
    vecs[9]  = '{1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 2'd0, 8'h10};
    vecs[10] = '{1'b1, 2'd0, 8'h12, 1'b0, 1'b0, 2'd0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 8'h10};
    vecs[11] = '{1'b1, 2'd2, 8'h13, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b1, 2'd0, 8'h10};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd1, 8'h11};
    vecs[14] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    vecs[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd2, 8'h13};
    vecs[16] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
  end

  // ---------------- test sequence ----------------
  logic [DW-1:0] rnd_d;

  initial begin
    idle(1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_in_ready",  bus.in_ready_o,  1'b1);
    chk("rst_count",     bus.count_o,     3'd0);
    chk("rst_afull",     bus.almost_full_o, 1'b0);
    chk("rst_overflow",  bus.overflow_o,  1'b0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].pid, DW'(vecs[i].d), vecs[i].ordy, 1'b0, vecs[i].kill, vecs[i].kpid);
      tick();
      chk($sformatf("row%0d_count", i), bus.count_o,       vecs[i].e_cnt);
      chk($sformatf("row%0d_valid", i), bus.out_valid_o,   vecs[i].e_ov);
      chk($sformatf("row%0d_ready", i), bus.in_ready_o,    vecs[i].e_ir);
      chk($sformatf("row%0d_afull", i), bus.almost_full_o, vecs[i].e_af);
      if (vecs[i].e_ov) begin
        chk($sformatf("row%0d_pid", i),  bus.out_pid_o,       vecs[i].e_pid);
        chk($sformatf("row%0d_data", i), bus.out_data_o[7:0], vecs[i].e_d);
      end
    end

    // streaming: output equals input delayed by one cycle, count holds at 1
    drive(1'b1, 2'd0, DW'(100), 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    chk("stream_first", bus.out_data_o, DW'(100));
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, PIDW'(i), DW'(100 + i), 1'b1, 1'b0, 1'b0, 2'd3);
      tick();
      chk($sformatf("stream%0d_count", i), bus.count_o, 3'd1);
      chk($sformatf("stream%0d_data", i),  bus.out_data_o, DW'(100 + i));
    end
    idle(1'b1);
    tick();
    chk("stream_end_count", bus.count_o, 3'd0);

    // full flush with a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
    end
    drive(1'b1, 2'd1, DW'(8'hFF), 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    chk("flush_count", bus.count_o,     3'd0);
    chk("flush_valid", bus.out_valid_o, 1'b0);
    chk("flush_ready", bus.in_ready_o,  1'b1);
    idle(1'b1);
    tick();
    chk("flush_push_dropped", bus.count_o, 3'd0);

    // overflow: push while full, data intact, flag sticky until reset
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 2'd2, DW'(8'h50 + i), 1'b0, 1'b0, 1'b0, 2'd0);
      exp_q.push_back(DW'(8'h50 + i));
      tick();
    end
    drive(1'b1, 2'd2, DW'(8'hEE), 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    tick();
    chk("ovf_flag",  bus.overflow_o, 1'b1);
    chk("ovf_count", bus.count_o,    3'd4);
    idle(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), bus.out_valid_o, 1'b1);
      chk($sformatf("ovf_drain%0d_data", i),  bus.out_data_o,  exp_q.pop_front());
      tick();
    end
    chk("ovf_sticky", bus.overflow_o, 1'b1);
    chk("ovf_empty",  bus.count_o,    3'd0);

    // reset mid-stream with push and pop active
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd3, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
    end
    drive(1'b1, 2'd3, DW'(8'h62), 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(1'b0);
    chk("mrst_valid", bus.out_valid_o,   1'b0);
    chk("mrst_ready", bus.in_ready_o,    1'b1);
    chk("mrst_count", bus.count_o,       3'd0);
    chk("mrst_afull", bus.almost_full_o, 1'b0);
    chk("mrst_ovf",   bus.overflow_o,    1'b0);
    drive(1'b1, 2'd1, DW'(8'h55), 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    idle(1'b1);
    chk("mrst_push_valid", bus.out_valid_o, 1'b1);
    chk("mrst_push_data",  bus.out_data_o,  DW'(8'h55));
    tick();

    // random traffic checked by the reference model every cycle
    for (int n = 0; n < 800; n++) begin
      for (int w = 0; w < 7; w++) rnd_d[w*32 +: 32] = $urandom;
      drive($urandom_range(0, 9) < 7, PIDW'($urandom_range(0, 3)), rnd_d,
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, PIDW'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle(1'b1);
    repeat (6) tick();
    chk("final_drained", bus.count_o, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
